read_from_cache: RTL and testbench
==================================

Name: read_from_cache

Overview:
- Read-side counterpart to the cache write path; returns one data word from a selected cache way to the CPU/control FSM.
- Accepts a read request (one-hot target way + line offset), drives read-enable to that way, and waits for the way's read ack.
- Captures the returned data word and holds it for the CPU under a valid/ready handshake.
- Flags a timeout or malformed way select as an error instead of hanging.

Parameters:
NUM_WAYS, 4, number of cache ways (one-hot select width)
DATA_WIDTH, 32, data word width
OFFSET_WIDTH, 4, word offset within a cache line
TIMEOUT_CYCLES, 16, maximum cycles in ISSUE without a way ack before error (must be >= 2)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
request  in  1  read request from control FSM
target_way  in  NUM_WAYS  one-hot way select for the request
offset  in  OFFSET_WIDTH  word offset within the line
request_ack  out  1  one-cycle pulse: request accepted
rd_data  out  DATA_WIDTH  returned word (0 on error)
rd_valid  out  1  rd_data/rd_err valid
rd_ready  in  1  consumer accepts rd_data
rd_err  out  1  response is an error (timeout or bad select); qualified by rd_valid
way_offset  out  OFFSET_WIDTH  offset broadcast to all ways
way_r_en  out  NUM_WAYS  per-way read enable
way_data_out  in  NUM_WAYS*DATA_WIDTH  packed way read data; way i at [i*DATA_WIDTH +: DATA_WIDTH]
way_r_ack  in  NUM_WAYS  per-way read ack; data valid in same cycle

Behaviour:
- Reset (async, reset_n low): state IDLE; request_ack=0, rd_valid=0, rd_err=0, rd_data=0, way_r_en=0, way_offset=0, timeout counter=0. Reset mid-transaction drops it; no response is produced.
- FSM states IDLE, ISSUE, RESP; all outputs registered or decoded from registers.
- IDLE:
  - On request=1: latch target_way/offset, pulse request_ack=1 the next cycle.
  - If target_way is one-hot: go to ISSUE.
  - Otherwise (zero or multiple bits set): go directly to RESP with rd_err=1, rd_data=0.
- ISSUE:
  - way_r_en = latched one-hot; way_offset = latched offset.
  - Counter increments each ISSUE cycle.
  - Only way_r_ack of the targeted way counts; acks from other ways are ignored.
  - On target ack: capture that way's data into rd_data, rd_err=0, go to RESP.
  - If no ack and counter == TIMEOUT_CYCLES-1: rd_data=0, rd_err=1, go to RESP.
  - Ack and timeout in the same cycle: ack wins.
- RESP:
  - way_r_en=0; rd_valid=1; rd_data and rd_err held stable until rd_valid & rd_ready.
  - On handshake with request=0: go to IDLE.
  - On handshake with request=1: accept the new request in the same cycle (request_ack pulse next cycle) and go to ISSUE, or to RESP/err for a bad select. Back-to-back reads are allowed.
  - Requests arriving in RESP without rd_ready are not accepted; request_ack stays 0.
- request_ack is a single-cycle pulse per accepted request, never asserted in consecutive cycles for one request.
- Latency, minimum: request at cycle 0 → request_ack and way_r_en at cycle 1 → way ack at cycle 1 → rd_valid at cycle 2.
- Counter width: $clog2(TIMEOUT_CYCLES); cleared on entry to ISSUE.

Decomposition:
- cache_pkg: read_state_e enum {IDLE, ISSUE, RESP}; onehot check function is_onehot(); shared DATA_WIDTH/OFFSET_WIDTH defaults.
- Sub-module way_data_select: combinational one-hot AND-OR mux of way_data_out by latched target (parameterised NUM_WAYS, DATA_WIDTH).
- FSM, counter and response register stay in read_from_cache.

Test Plan:
- Basic read: request, target_way=4'b0100, offset=3; way 2 acks at cycle 1 with 0xDEADBEEF; rd_ready=1 → request_ack at cycle 1, way_r_en=4'b0100 and way_offset=3 at cycle 1, rd_valid at cycle 2 with rd_data=0xDEADBEEF and rd_err=0.
- Backpressure: rd_ready=0 for 5 cycles after rd_valid → rd_data stable, no new request_ack despite request=1; on rd_ready=1 the second request is accepted in the same cycle.
- Bad select: target_way=4'b0000, then target_way=4'b0011 → no way_r_en; rd_valid next+1 with rd_err=1, rd_data=0.
- Timeout: target_way=4'b0001, no ack → way_r_en held exactly 16 cycles, then rd_valid with rd_err=1; an ack on way 3 during the wait is ignored.
- Ack on the final timeout cycle: target acks at counter=15 → rd_err=0, data captured.
- Reset mid-ISSUE: reset_n low during wait → all outputs 0 immediately; after release, no stale rd_valid; a new request completes normally.

Source files
------------

// File: rtl/read_from_cache_pkg.sv
`default_nettype none
// ============================================================================
// cache_pkg : shared types and helpers for the cache read path
// Revision  : 1.0
// ============================================================================
package cache_pkg;

  localparam int DATA_WIDTH_DEF   = 32;
  localparam int OFFSET_WIDTH_DEF = 4;
  localparam int MAX_WAYS         = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } read_state_e;

  // Callers zero-extend narrower way vectors to MAX_WAYS bits.
  function automatic logic is_onehot(input logic [MAX_WAYS-1:0] v);
    return (v != '0) && ((v & (v - MAX_WAYS'(1))) == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/read_from_cache_way_data_select.sv
`default_nettype none
// ============================================================================
// way_data_select : one-hot AND-OR mux of the packed per-way read data
// Revision        : 1.0
// ============================================================================
module way_data_select #(
  parameter int NUM_WAYS   = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic [NUM_WAYS-1:0]            sel,
  input  logic [NUM_WAYS*DATA_WIDTH-1:0] way_data,
  output logic [DATA_WIDTH-1:0]          data
);

  always_comb begin
    data = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (sel[i]) data = data | way_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule
`default_nettype wire

// File: rtl/read_from_cache.sv
`default_nettype none
// ============================================================================
// read_from_cache : fetches one word from a selected cache way for the CPU
// Revision        : 1.0
// ============================================================================
module read_from_cache
  import cache_pkg::*;
#(
  parameter int NUM_WAYS       = 4,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int OFFSET_WIDTH   = OFFSET_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           request,
  input  logic [NUM_WAYS-1:0]            target_way,
  input  logic [OFFSET_WIDTH-1:0]        offset,
  output logic                           request_ack,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           rd_valid,
  input  logic                           rd_ready,
  output logic                           rd_err,
  output logic [OFFSET_WIDTH-1:0]        way_offset,
  output logic [NUM_WAYS-1:0]            way_r_en,
  input  logic [NUM_WAYS*DATA_WIDTH-1:0] way_data_out,
  input  logic [NUM_WAYS-1:0]            way_r_ack
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  read_state_e           state;
  logic [NUM_WAYS-1:0]   lat_way;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  accept;
  logic                  target_ack;
  logic                  req_onehot;

  way_data_select #(
    .NUM_WAYS   (NUM_WAYS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sel (
    .sel      (lat_way),
    .way_data (way_data_out),
    .data     (sel_data)
  );

  // A new request is taken from IDLE, or from RESP in the handshake cycle.
  assign accept     = request && ((state == IDLE) || ((state == RESP) && rd_ready));
  assign target_ack = |(way_r_ack & lat_way);
  assign req_onehot = is_onehot(MAX_WAYS'(target_way));
  assign way_r_en   = (state == ISSUE) ? lat_way : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      lat_way     <= '0;
      way_offset  <= '0;
      cnt         <= '0;
      request_ack <= 1'b0;
      rd_valid    <= 1'b0;
      rd_err      <= 1'b0;
      rd_data     <= '0;
    end else begin
      request_ack <= accept;
      if (accept) begin
        lat_way    <= target_way;
        way_offset <= offset;
        cnt        <= '0;
        if (req_onehot) begin
          state    <= ISSUE;
          rd_valid <= 1'b0;
          rd_err   <= 1'b0;
        end else begin
          state    <= RESP;
          rd_valid <= 1'b1;
          rd_err   <= 1'b1;
          rd_data  <= '0;
        end
      end else begin
        case (state)
          ISSUE: begin
            if (target_ack) begin
              state    <= RESP;
              rd_valid <= 1'b1;
              rd_err   <= 1'b0;
              rd_data  <= sel_data;
            end else if (cnt == CNT_LAST) begin
              state    <= RESP;
              rd_valid <= 1'b1;
              rd_err   <= 1'b1;
              rd_data  <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          RESP: begin
            if (rd_ready) begin
              state    <= IDLE;
              rd_valid <= 1'b0;
              rd_err   <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_read_from_cache.sv
`default_nettype none
// ============================================================================
// tb_read_from_cache : directed self-checking bench for read_from_cache
// Revision           : 1.0
// ============================================================================
module tb_read_from_cache;

  localparam int NW = 4;
  localparam int DW = 32;
  localparam int OW = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             request;
  logic [NW-1:0]    target_way;
  logic [OW-1:0]    offset;
  logic             request_ack;
  logic [DW-1:0]    rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic             rd_err;
  logic [OW-1:0]    way_offset;
  logic [NW-1:0]    way_r_en;
  logic [NW*DW-1:0] way_data_out;
  logic [NW-1:0]    way_r_ack;

  int checks = 0;
  int errors = 0;

  read_from_cache #(
    .NUM_WAYS(NW), .DATA_WIDTH(DW), .OFFSET_WIDTH(OW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .request(request), .target_way(target_way),
    .offset(offset), .request_ack(request_ack), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_err(rd_err),
    .way_offset(way_offset), .way_r_en(way_r_en),
    .way_data_out(way_data_out), .way_r_ack(way_r_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_resp(input string tag, input logic v, input logic e, input logic [DW-1:0] d);
    check({tag, ".rd_valid"}, 64'(rd_valid), 64'(v));
    check({tag, ".rd_err"},   64'(rd_err),   64'(e));
    check({tag, ".rd_data"},  64'(rd_data),  64'(d));
  endtask

  initial begin
    int n;
    reset_n      = 1'b0;
    request      = 1'b0;
    target_way   = '0;
    offset       = '0;
    rd_ready     = 1'b0;
    way_r_ack    = '0;
    way_data_out = {32'h33333333, 32'hDEADBEEF, 32'h11111111, 32'h00000000};

    // Reset state
    tick(); tick();
    check("rst.request_ack", 64'(request_ack), 64'd0);
    check("rst.way_r_en",    64'(way_r_en),    64'd0);
    check("rst.way_offset",  64'(way_offset),  64'd0);
    check_resp("rst", 1'b0, 1'b0, 32'h0);
    reset_n = 1'b1;
    tick();

    // Basic read, way 2, offset 3
    request = 1'b1; target_way = 4'b0100; offset = 4'd3; rd_ready = 1'b1;
    tick();
    check("basic.request_ack", 64'(request_ack), 64'd1);
    check("basic.way_r_en",    64'(way_r_en),    64'b0100);
    check("basic.way_offset",  64'(way_offset),  64'd3);
    check("basic.rd_valid0",   64'(rd_valid),    64'd0);
    request = 1'b0; way_r_ack = 4'b0100;
    tick();
    way_r_ack = '0;
    check_resp("basic", 1'b1, 1'b0, 32'hDEADBEEF);
    check("basic.ack_pulse", 64'(request_ack), 64'd0);
    check("basic.r_en_off",  64'(way_r_en),    64'd0);
    tick();
    check("basic.idle_valid", 64'(rd_valid), 64'd0);

    // Backpressure with a pending second request
    rd_ready = 1'b0; request = 1'b1; target_way = 4'b0010; offset = 4'd5;
    way_data_out[1*DW +: DW] = 32'h12345678;
    tick();
    check("bp.request_ack", 64'(request_ack), 64'd1);
    check("bp.way_r_en",    64'(way_r_en),    64'b0010);
    target_way = 4'b1000; offset = 4'd7; way_r_ack = 4'b0010;
    tick();
    way_r_ack = '0;
    check_resp("bp.first", 1'b1, 1'b0, 32'h12345678);
    check("bp.no_ack_issue", 64'(request_ack), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_resp("bp.hold", 1'b1, 1'b0, 32'h12345678);
      check("bp.no_ack", 64'(request_ack), 64'd0);
    end
    rd_ready = 1'b1;
    tick();
    check("bp.second_ack",  64'(request_ack), 64'd1);
    check("bp.second_en",   64'(way_r_en),    64'b1000);
    check("bp.second_off",  64'(way_offset),  64'd7);
    check("bp.second_v0",   64'(rd_valid),    64'd0);
    request = 1'b0; way_data_out[3*DW +: DW] = 32'hCAFEF00D; way_r_ack = 4'b1000;
    tick();
    way_r_ack = '0;
    check_resp("bp.second", 1'b1, 1'b0, 32'hCAFEF00D);
    tick();
    check("bp.idle", 64'(rd_valid), 64'd0);

    // Bad selects: none and multiple ways
    request = 1'b1; target_way = 4'b0000; offset = 4'd1;
    tick();
    request = 1'b0;
    check("bad0.request_ack", 64'(request_ack), 64'd1);
    check("bad0.way_r_en",    64'(way_r_en),    64'd0);
    check_resp("bad0", 1'b1, 1'b1, 32'h0);
    tick();
    check("bad0.idle", 64'(rd_valid), 64'd0);
    request = 1'b1; target_way = 4'b0011;
    tick();
    request = 1'b0;
    check("bad3.request_ack", 64'(request_ack), 64'd1);
    check("bad3.way_r_en",    64'(way_r_en),    64'd0);
    check_resp("bad3", 1'b1, 1'b1, 32'h0);
    tick();
    check("bad3.idle", 64'(rd_valid), 64'd0);

    // Timeout on way 0 while way 3 acks
    request = 1'b1; target_way = 4'b0001; offset = 4'd2;
    tick();
    request = 1'b0; way_r_ack = 4'b1000;
    n = 0;
    while (way_r_en == 4'b0001 && n < 40) begin
      n++;
      check("to.no_valid", 64'(rd_valid), 64'd0);
      tick();
    end
    way_r_ack = '0;
    check("to.en_cycles", 64'(n), 64'd16);
    check_resp("to", 1'b1, 1'b1, 32'h0);
    tick();
    check("to.idle", 64'(rd_valid), 64'd0);

    // Target ack on the last allowed cycle wins over timeout
    request = 1'b1; target_way = 4'b0001; way_data_out[0 +: DW] = 32'hA5A5A5A5;
    tick();
    request = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("last.still_en", 64'(way_r_en), 64'b0001);
    check("last.no_valid", 64'(rd_valid), 64'd0);
    way_r_ack = 4'b0001;
    tick();
    way_r_ack = '0;
    check_resp("last", 1'b1, 1'b0, 32'hA5A5A5A5);
    tick();

    // Reset in the middle of ISSUE
    request = 1'b1; target_way = 4'b0100; offset = 4'd9;
    tick();
    request = 1'b0;
    tick();
    check("mid.way_r_en", 64'(way_r_en), 64'b0100);
    reset_n = 1'b0;
    #1;
    check("mid.rst_en",  64'(way_r_en),    64'd0);
    check("mid.rst_off", 64'(way_offset),  64'd0);
    check("mid.rst_ack", 64'(request_ack), 64'd0);
    check_resp("mid.rst", 1'b0, 1'b0, 32'h0);
    tick();
    reset_n = 1'b1;
    way_r_ack = 4'b0100;
    tick(); tick();
    way_r_ack = '0;
    check("mid.no_stale", 64'(rd_valid),    64'd0);
    check("mid.no_ack",   64'(request_ack), 64'd0);
    request = 1'b1; target_way = 4'b0100; offset = 4'd6;
    tick();
    request = 1'b0;
    check("mid.new_ack", 64'(request_ack), 64'd1);
    check("mid.new_off", 64'(way_offset),  64'd6);
    way_r_ack = 4'b0100;
    tick();
    way_r_ack = '0;
    check_resp("mid.new", 1'b1, 1'b0, 32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
